sar_search_3bit: RTL and testbench
==================================

SAR_SEARCH_3BIT -- requirements
Module: sar_search_3bit

Interface
REQ-001 The block SHALL have no parameters; the search width is fixed at 3 bits (range 0..7).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 GT  input  1  external comparator result: hidden value > guess.
REQ-006 LT  input  1  external comparator result: hidden value < guess.
REQ-007 EQ  input  1  external comparator result: hidden value == guess.
REQ-008 guess  output  3  current probe value driven to the external comparator's B input.
REQ-009 busy  output  1  high while in PROBE.
REQ-010 done  output  1  one-cycle pulse when a search ends, whether found or error.
REQ-011 result  output  3  found value, held until the next accepted start.
REQ-012 err  output  1  search ended abnormally, held until the next accepted start.
REQ-013 probes  output  3  number of compare cycles used by the last or current search.

Function
REQ-014 The block SHALL implement FSM states IDLE, PROBE and DONE, with internal 3-bit lo/hi bounds.
REQ-015 In IDLE, guess SHALL be 0 and the GT/LT/EQ inputs SHALL be ignored.
REQ-016 IDLE with start=1 SHALL set lo=0, hi=7, probes=0, result=0, err=0, then enter PROBE next cycle.
REQ-017 In PROBE, guess SHALL be combinational (lo+hi)>>1, with the sum computed at 4 bits (no overflow).
REQ-018 Each PROBE clock edge SHALL sample GT/LT/EQ, since the comparator is combinational on guess, and SHALL increment probes.
REQ-019 EQ only: result=guess, go to DONE.
REQ-020 GT only: if guess==hi, set err=1 and go to DONE; otherwise lo=guess+1 and stay in PROBE.
REQ-021 LT only: if guess==lo, set err=1 and go to DONE; otherwise hi=guess-1 and stay in PROBE. Underflow at guess 0 is never performed.
REQ-022 Zero or more than one of GT/LT/EQ asserted: set err=1, result=guess, go to DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-024 start SHALL be ignored in PROBE and DONE; no queuing.
REQ-025 A consistent comparator SHALL always resolve in 1..4 probes; value 7 takes 4 (guesses 3,5,6,7).
REQ-026 Latency from start sampled to done pulse SHALL be probes+1 cycles.
REQ-027 result, err and probes SHALL hold their values in IDLE until the next accepted start.
REQ-028 busy SHALL be 1 exactly when state==PROBE; done SHALL be 1 exactly when state==DONE.

Reset
REQ-029 rst_n=0 SHALL, asynchronously and at any time including mid-search, force state IDLE, lo=0, hi=7, and guess=0, busy=0, done=0, result=0, err=0, probes=0.
REQ-030 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-031 Model a comparator with hidden A=5, pulse start -> guesses 3,5; done pulse with result=5, err=0, probes=2.
REQ-032 Hidden A=7 -> guesses 3,5,6,7; result=7, probes=4. Hidden A=0 -> guesses 3,1,0; result=0, probes=3.
REQ-033 Sweep all A in 0..7 -> result==A, err=0, probes<=4, done high exactly one cycle each time.
REQ-034 Force GT=LT=1 on the first probe -> done next edge with err=1, result=3, probes=1. Force GT on guess 7 -> err=1.
REQ-035 Assert rst_n=0 during the second probe -> outputs zero immediately; a new start after release completes normally.
REQ-036 Pulse start while busy and during DONE -> ignored; no restart, no second done pulse.

Source files
------------

// File: rtl/sar_search_3bit.sv
// 3-bit successive-approximation search: binary-searches a hidden value 0..7
// by probing an external combinational comparator with guess each cycle.
module sar_search_3bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       GT,
  input  logic       LT,
  input  logic       EQ,
  output logic [2:0] guess,
  output logic       busy,
  output logic       done,
  output logic [2:0] result,
  output logic       err,
  output logic [2:0] probes
);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] lo, hi;
  logic [3:0] sum;
  logic       eq_only, gt_only, lt_only, cmp_bad;
  logic       gt_err, lt_err;

  // Sum kept at 4 bits so lo+hi never wraps before halving.
  assign sum     = {1'b0, lo} + {1'b0, hi};
  assign eq_only =  EQ & ~GT & ~LT;
  assign gt_only =  GT & ~LT & ~EQ;
  assign lt_only =  LT & ~GT & ~EQ;
  assign cmp_bad = ~(eq_only | gt_only | lt_only);
  assign gt_err  = gt_only & (guess == hi);
  assign lt_err  = lt_only & (guess == lo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PROBE;
      PROBE:   if (eq_only || cmp_bad || gt_err || lt_err) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    guess = 3'd0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      PROBE:   begin guess = sum[3:1]; busy = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Bounds and search outcome; result/err/probes persist through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo     <= 3'd0;
      hi     <= 3'd7;
      result <= 3'd0;
      err    <= 1'b0;
      probes <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lo     <= 3'd0;
            hi     <= 3'd7;
            result <= 3'd0;
            err    <= 1'b0;
            probes <= 3'd0;
          end
        end
        PROBE: begin
          probes <= probes + 3'd1;
          if (eq_only) begin
            result <= guess;
          end else if (cmp_bad) begin
            err    <= 1'b1;
            result <= guess;
          end else if (gt_only) begin
            if (gt_err) err <= 1'b1;
            else        lo  <= guess + 3'd1;
          end else begin
            if (lt_err) err <= 1'b1;
            else        hi  <= guess - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search_3bit.sv
// Directed bench for sar_search_3bit with a behavioural comparator that can
// also be forced into inconsistent answers.
module tb_sar_search_3bit;

  logic       clk = 1'b0;
  logic       rst_n, start, GT, LT, EQ;
  logic [2:0] guess, result, probes;
  logic       busy, done, err;

  int         vectors = 0;
  int         miscompares = 0;
  int         hidden = 0;
  int         mode = 0;
  int         exp_g[4];

  sar_search_3bit dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .GT(GT), .LT(LT), .EQ(EQ),
    .guess(guess), .busy(busy), .done(done),
    .result(result), .err(err), .probes(probes)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1:       begin GT = 1'b1; LT = 1'b1; EQ = 1'b0; end
      2:       begin GT = 1'b1; LT = 1'b0; EQ = 1'b0; end
      default: begin
        GT = (hidden > int'(guess));
        LT = (hidden < int'(guess));
        EQ = (hidden == int'(guess));
      end
    endcase
  end

  task automatic chk(input string tag, input int obs, input int expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Entered on a negedge; returns on the negedge after the done cycle.
  task automatic search(input int a, input int ng, input int np,
                        input int res, input int e);
    int cnt;
    hidden = a;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy && cnt < 8) begin
      if (cnt < ng) chk($sformatf("guess[%0d] a=%0d", cnt, a), int'(guess), exp_g[cnt]);
      cnt++;
      @(negedge clk);
    end
    chk($sformatf("busy_cycles a=%0d", a), cnt, np);
    chk($sformatf("done a=%0d", a), int'(done), 1);
    chk($sformatf("result a=%0d", a), int'(result), res);
    chk($sformatf("err a=%0d", a), int'(err), e);
    chk($sformatf("probes a=%0d", a), int'(probes), np);
    @(negedge clk);
    chk($sformatf("done_pulse_end a=%0d", a), int'(done), 0);
    chk($sformatf("result_hold a=%0d", a), int'(result), res);
    chk($sformatf("probes_hold a=%0d", a), int'(probes), np);
  endtask

  initial begin
    int sweep_p[8];
    int dones;
    sweep_p = '{3, 2, 3, 1, 3, 2, 3, 4};
    rst_n = 1'b0;
    start = 1'b0;
    hidden = 4;
    #12;
    chk("rst_guess", int'(guess), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_probes", int'(probes), 0);
    @(negedge clk);
    rst_n = 1'b1;

    exp_g = '{3, 5, 0, 0};
    search(5, 2, 2, 5, 0);
    chk("idle_guess", int'(guess), 0);
    exp_g = '{3, 5, 6, 7};
    search(7, 4, 4, 7, 0);
    exp_g = '{3, 1, 0, 0};
    search(0, 3, 3, 0, 0);

    for (int a = 0; a < 8; a++) search(a, 0, sweep_p[a], a, 0);

    mode = 1;
    exp_g = '{3, 0, 0, 0};
    search(2, 1, 1, 3, 1);
    mode = 2;
    exp_g = '{3, 5, 6, 7};
    search(2, 4, 4, 0, 1);
    mode = 0;

    // Reset during the second probe.
    hidden = 5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_guess2", int'(guess), 5);
    rst_n = 1'b0;
    #1;
    chk("arst_guess", int'(guess), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_probes", int'(probes), 0);
    chk("arst_result", int'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_g = '{3, 5, 6, 0};
    search(6, 3, 3, 6, 0);

    // start held high through PROBE and DONE must not restart.
    hidden = 7;
    start = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dones++;
      chk($sformatf("no_restart_busy%0d", i), int'(busy), 0);
    end
    chk("single_done", dones, 1);
    chk("hold_probes", int'(probes), 4);
    chk("hold_result", int'(result), 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
